// File: rtl/switch_debounce_pkg.sv
// Shared types and default parameter values for the switch debouncer.
package switch_debounce_pkg;

   typedef enum logic {
      DB_STABLE  = 1'b0,
      DB_PENDING = 1'b1
   } db_state_t;

   localparam int DEFAULT_NUM_SW        = 3;
   localparam int DEFAULT_STABLE_CYCLES = 500000;
   localparam int DEFAULT_SYNC_STAGES   = 2;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: input synchroniser, debounce FSM with saturating counter.
// Optional registered edge pulses when DEBOUNCE_EDGE_OUT_EN is defined.
module debounce_channel
   import switch_debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
   parameter bit SW_INVERT     = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic switch_in,
`ifdef DEBOUNCE_EDGE_OUT_EN
   output logic switch_rise,
   output logic switch_fall,
`endif
   output logic switch_stable
);

   localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_in;
   logic                   w_sync;
   db_state_t              r_state;
   db_state_t              w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic                   r_stable;
   logic                   w_stable_nxt;

   assign w_in   = switch_in ^ SW_INVERT;
   assign w_sync = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync   <= '0;
         r_state  <= DB_STABLE;
         r_cnt    <= '0;
         r_stable <= 1'b0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], w_in};
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_stable <= w_stable_nxt;
      end
   end

   // Counter saturates at CNT_MAX: the cycle after reaching it is the acceptance cycle.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_stable_nxt = r_stable;
      case (r_state)
         DB_STABLE: begin
            if (w_sync != r_stable) begin
               w_state_nxt = DB_PENDING;
               w_cnt_nxt   = CNT_ONE;
            end else begin
               w_cnt_nxt = '0;
            end
         end
         DB_PENDING: begin
            if (w_sync == r_stable) begin
               w_state_nxt = DB_STABLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt < CNT_MAX) begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end else begin
               w_stable_nxt = w_sync;
               w_cnt_nxt    = '0;
               w_state_nxt  = DB_STABLE;
            end
         end
         default: begin
            w_state_nxt = DB_STABLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign switch_stable = r_stable;

`ifdef DEBOUNCE_EDGE_OUT_EN
   logic r_rise;
   logic r_fall;

   // Registered alongside r_stable so a pulse coincides with the first cycle of the new level.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= w_stable_nxt & ~r_stable;
         r_fall <= ~w_stable_nxt & r_stable;
      end
   end

   assign switch_rise = r_rise;
   assign switch_fall = r_fall;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Debounces NUM_SW raw switches into clock-domain levels; one independent channel per switch.
// Edge pulse outputs exist only when DEBOUNCE_EDGE_OUT_EN is defined.
module switch_debouncer
   import switch_debounce_pkg::*;
#(
   parameter int NUM_SW        = DEFAULT_NUM_SW,
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
   parameter bit SW_INVERT     = 1'b0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NUM_SW-1:0] switch_in,
`ifdef DEBOUNCE_EDGE_OUT_EN
   output logic [NUM_SW-1:0] switch_rise,
   output logic [NUM_SW-1:0] switch_fall,
`endif
   output logic [NUM_SW-1:0] switch_stable
);

   for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .SYNC_STAGES   (SYNC_STAGES),
         .SW_INVERT     (SW_INVERT)
      ) u_ch (
         .clock         (clock),
         .reset         (reset),
         .switch_in     (switch_in[g]),
`ifdef DEBOUNCE_EDGE_OUT_EN
         .switch_rise   (switch_rise[g]),
         .switch_fall   (switch_fall[g]),
`endif
         .switch_stable (switch_stable[g])
      );
   end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with STABLE_CYCLES=8, SYNC_STAGES=2.
// Inputs change just after a rising edge; the next edge is cycle T, so a change appears after edge T+10.
module tb_switch_debouncer;

   logic       clock = 1'b0;
   logic       reset;
   logic [2:0] switch_in;
   logic [2:0] switch_stable;
`ifdef DEBOUNCE_EDGE_OUT_EN
   logic [2:0] switch_rise;
   logic [2:0] switch_fall;
`endif

   int checks = 0;
   int errors = 0;

   switch_debouncer #(
      .NUM_SW        (3),
      .STABLE_CYCLES (8),
      .SYNC_STAGES   (2),
      .SW_INVERT     (1'b0)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .switch_in     (switch_in),
`ifdef DEBOUNCE_EDGE_OUT_EN
      .switch_rise   (switch_rise),
      .switch_fall   (switch_fall),
`endif
      .switch_stable (switch_stable)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic hold(input int n);
      repeat (n) tick();
   endtask

   task automatic test_reset();
      logic [2:0] exp_s;
      logic [2:0] exp_r;
      switch_in = 3'b111;
      reset     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (switch_stable !== 3'b000) begin
            errors++;
            $display("FAIL reset_stable: got %b expected 000", switch_stable);
         end
      end
      reset = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         exp_s = (i >= 11) ? 3'b111 : 3'b000;
         exp_r = (i == 11) ? 3'b111 : 3'b000;
         checks++;
         if (switch_stable !== exp_s) begin
            errors++;
            $display("FAIL reset_release_stable[%0d]: got %b expected %b", i, switch_stable, exp_s);
         end
`ifdef DEBOUNCE_EDGE_OUT_EN
         checks++;
         if (switch_rise !== exp_r) begin
            errors++;
            $display("FAIL reset_release_rise[%0d]: got %b expected %b", i, switch_rise, exp_r);
         end
`endif
      end
   endtask

   task automatic test_single_rise();
      logic [2:0] exp_s;
      logic [2:0] exp_r;
      switch_in = 3'b110;
      hold(14);
      switch_in = 3'b111;
      for (int i = 1; i <= 12; i++) begin
         tick();
         exp_s = (i >= 11) ? 3'b111 : 3'b110;
         exp_r = (i == 11) ? 3'b001 : 3'b000;
         checks++;
         if (switch_stable !== exp_s) begin
            errors++;
            $display("FAIL single_stable[%0d]: got %b expected %b", i, switch_stable, exp_s);
         end
`ifdef DEBOUNCE_EDGE_OUT_EN
         checks++;
         if (switch_rise !== exp_r || switch_fall !== 3'b000) begin
            errors++;
            $display("FAIL single_edges[%0d]: got rise %b fall %b expected rise %b fall 000",
                     i, switch_rise, switch_fall, exp_r);
         end
`endif
      end
   endtask

   task automatic test_bounce();
      logic [2:0] exp_s;
      int         rises;
      switch_in = 3'b000;
      hold(14);
      rises = 0;
      for (int seg = 0; seg < 10; seg++) begin
         switch_in[1] = (seg % 2 == 0);
         for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (switch_stable !== 3'b000) begin
               errors++;
               $display("FAIL bounce_hold[%0d]: got %b expected 000", seg, switch_stable);
            end
`ifdef DEBOUNCE_EDGE_OUT_EN
            if (switch_rise[1]) rises++;
`endif
         end
      end
      switch_in[1] = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         exp_s = (i >= 11) ? 3'b010 : 3'b000;
         checks++;
         if (switch_stable !== exp_s) begin
            errors++;
            $display("FAIL bounce_settle[%0d]: got %b expected %b", i, switch_stable, exp_s);
         end
`ifdef DEBOUNCE_EDGE_OUT_EN
         if (switch_rise[1]) rises++;
`endif
      end
`ifdef DEBOUNCE_EDGE_OUT_EN
      checks++;
      if (rises !== 1) begin
         errors++;
         $display("FAIL bounce_rise_count: got %0d expected 1", rises);
      end
`endif
   endtask

   task automatic test_glitch();
      switch_in = 3'b000;
      hold(14);
      switch_in[2] = 1'b1;
      for (int i = 0; i < 27; i++) begin
         if (i == 7) switch_in[2] = 1'b0;
         tick();
         checks++;
         if (switch_stable !== 3'b000) begin
            errors++;
            $display("FAIL glitch_stable[%0d]: got %b expected 000", i, switch_stable);
         end
`ifdef DEBOUNCE_EDGE_OUT_EN
         checks++;
         if (switch_rise !== 3'b000 || switch_fall !== 3'b000) begin
            errors++;
            $display("FAIL glitch_edges[%0d]: got rise %b fall %b expected 000/000",
                     i, switch_rise, switch_fall);
         end
`endif
      end
   endtask

   task automatic test_multi();
      logic [2:0] old_v;
      logic [2:0] exp_s;
      logic [2:0] exp_r;
      logic [2:0] exp_f;
      switch_in = 3'b000;
      hold(14);
      old_v = 3'b000;
      for (int v = 8; v >= 0; v--) begin
         // first pass applies 101, then steps through all eight combinations
         switch_in = (v == 8) ? 3'b101 : 3'(7 - v);
         for (int i = 1; i <= 20; i++) begin
            tick();
            exp_s = (i >= 11) ? switch_in : old_v;
            exp_r = (i == 11) ? (switch_in & ~old_v) : 3'b000;
            exp_f = (i == 11) ? (~switch_in & old_v) : 3'b000;
            checks++;
            if (switch_stable !== exp_s) begin
               errors++;
               $display("FAIL multi_stable[%b,%0d]: got %b expected %b", switch_in, i, switch_stable, exp_s);
            end
`ifdef DEBOUNCE_EDGE_OUT_EN
            checks++;
            if (switch_rise !== exp_r || switch_fall !== exp_f) begin
               errors++;
               $display("FAIL multi_edges[%b,%0d]: got rise %b fall %b expected rise %b fall %b",
                        switch_in, i, switch_rise, switch_fall, exp_r, exp_f);
            end
`endif
         end
         old_v = switch_in;
      end
   endtask

   task automatic test_reset_midcount();
      logic [2:0] exp_s;
      logic [2:0] exp_r;
      switch_in = 3'b000;
      reset     = 1'b1;
      hold(2);
      reset = 1'b0;
      hold(4);
      switch_in = 3'b001;
      // seven edges later the counter holds 5
      for (int i = 0; i < 7; i++) begin
         tick();
         checks++;
         if (switch_stable !== 3'b000) begin
            errors++;
            $display("FAIL midcount_pending[%0d]: got %b expected 000", i, switch_stable);
         end
      end
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (switch_stable !== 3'b000) begin
            errors++;
            $display("FAIL midcount_reset[%0d]: got %b expected 000", i, switch_stable);
         end
`ifdef DEBOUNCE_EDGE_OUT_EN
         checks++;
         if (switch_rise !== 3'b000) begin
            errors++;
            $display("FAIL midcount_reset_rise[%0d]: got %b expected 000", i, switch_rise);
         end
`endif
      end
      reset = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         exp_s = (i >= 11) ? 3'b001 : 3'b000;
         exp_r = (i == 11) ? 3'b001 : 3'b000;
         checks++;
         if (switch_stable !== exp_s) begin
            errors++;
            $display("FAIL midcount_release[%0d]: got %b expected %b", i, switch_stable, exp_s);
         end
`ifdef DEBOUNCE_EDGE_OUT_EN
         checks++;
         if (switch_rise !== exp_r) begin
            errors++;
            $display("FAIL midcount_release_rise[%0d]: got %b expected %b", i, switch_rise, exp_r);
         end
`endif
      end
   endtask

   initial begin
      reset     = 1'b1;
      switch_in = 3'b000;
      test_reset();
      test_single_rise();
      test_bounce();
      test_glitch();
      test_multi();
      test_reset_midcount();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
